// File: rtl/ysyx_22041752_trap_seq.sv
// Trap/return sequencer: drives the single CSR write port through the ecall/interrupt/mret
// save-restore sequence, then pulses a PC redirect. Optional macro: YSYX_22041752_VECTORED_EN.
module ysyx_22041752_trap_seq #(
    parameter logic [63:0] CAUSE_ECALL = 64'd11,
    parameter logic [63:0] CAUSE_MTI   = 64'h8000_0000_0000_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ecall_i,
    input  logic        mret_i,
    input  logic        int_t_i,
    input  logic [63:0] epc_i,
    input  logic        pipe_wen_i,
    input  logic [11:0] pipe_addr_i,
    input  logic [63:0] pipe_wdata_i,
    output logic        csr_wen_o,
    output logic [11:0] csr_addr_o,
    output logic [63:0] csr_wdata_o,
    input  logic [63:0] csr_rdata_i,
    output logic        busy_o,
    output logic        redir_valid_o,
    output logic [63:0] redir_pc_o
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_T_EPC    = 3'd1;
    localparam logic [2:0] S_T_CAUSE  = 3'd2;
    localparam logic [2:0] S_T_STATUS = 3'd3;
    localparam logic [2:0] S_T_TVEC   = 3'd4;
    localparam logic [2:0] S_R_STATUS = 3'd5;
    localparam logic [2:0] S_R_EPC    = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [63:0] epc_q, epc_d;
    logic        is_int_q, is_int_d;

    logic [63:0] cause;
    logic [63:0] tvec_base;
    logic [63:0] tvec_pc;
    logic        wen_raw;
    logic        redir_raw;

    assign cause     = is_int_q ? CAUSE_MTI : CAUSE_ECALL;
    assign tvec_base = {csr_rdata_i[63:2], 2'b00};

`ifdef YSYX_22041752_VECTORED_EN
    // Vectored mode only offsets interrupts; synchronous exceptions still use the base.
    assign tvec_pc = (csr_rdata_i[1:0] == 2'b01 && cause[63])
                   ? tvec_base + {56'd0, cause[5:0], 2'b00}
                   : tvec_base;
`else
    assign tvec_pc = tvec_base;
`endif

    always_comb begin
        state_d     = state_q;
        epc_d       = epc_q;
        is_int_d    = is_int_q;
        wen_raw     = 1'b0;
        csr_addr_o  = '0;
        csr_wdata_o = '0;
        redir_raw   = 1'b0;
        redir_pc_o  = '0;
        case (state_q)
            S_IDLE: begin
                wen_raw     = pipe_wen_i;
                csr_addr_o  = pipe_addr_i;
                csr_wdata_o = pipe_wdata_i;
                if (int_t_i) begin
                    epc_d    = epc_i;
                    is_int_d = 1'b1;
                    state_d  = S_T_EPC;
                end else if (ecall_i) begin
                    epc_d    = epc_i;
                    is_int_d = 1'b0;
                    state_d  = S_T_EPC;
                end else if (mret_i) begin
                    state_d  = S_R_STATUS;
                end
            end
            S_T_EPC: begin
                wen_raw     = 1'b1;
                csr_addr_o  = ADDR_MEPC;
                csr_wdata_o = epc_q;
                state_d     = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                wen_raw     = 1'b1;
                csr_addr_o  = ADDR_MCAUSE;
                csr_wdata_o = cause;
                state_d     = S_T_STATUS;
            end
            S_T_STATUS: begin
                wen_raw            = 1'b1;
                csr_addr_o         = ADDR_MSTATUS;
                csr_wdata_o        = csr_rdata_i;
                csr_wdata_o[7]     = csr_rdata_i[3];
                csr_wdata_o[3]     = 1'b0;
                csr_wdata_o[12:11] = 2'b11;
                state_d            = S_T_TVEC;
            end
            S_T_TVEC: begin
                csr_addr_o = ADDR_MTVEC;
                redir_raw  = 1'b1;
                redir_pc_o = tvec_pc;
                state_d    = S_IDLE;
            end
            S_R_STATUS: begin
                wen_raw            = 1'b1;
                csr_addr_o         = ADDR_MSTATUS;
                csr_wdata_o        = csr_rdata_i;
                csr_wdata_o[3]     = csr_rdata_i[7];
                csr_wdata_o[7]     = 1'b1;
                csr_wdata_o[12:11] = 2'b11;
                state_d            = S_R_EPC;
            end
            S_R_EPC: begin
                csr_addr_o = ADDR_MEPC;
                redir_raw  = 1'b1;
                redir_pc_o = csr_rdata_i;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Reset must silence side effects in the same cycle, before the state register clears.
        if (reset) begin
            redir_pc_o = '0;
        end
    end

    assign csr_wen_o     = wen_raw & ~reset;
    assign redir_valid_o = redir_raw & ~reset;
    assign busy_o        = (state_q != S_IDLE) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            epc_q    <= '0;
            is_int_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            is_int_q <= is_int_d;
        end
    end

endmodule
